// File: rtl/btn_pkg.sv
// Shared constants for the button press classifier: FSM state encoding
// and default timing for a 100 MHz system clock.
package btn_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;

    localparam int LONG_PRESS_1S = 100_000_000;
    localparam int REPEAT_200MS  = 20_000_000;

endpackage

// File: rtl/btn_press_classifier.sv
// Classifies a debounced button level into short press, long press,
// auto-repeat while held, and release-after-long events.
// All outputs are registered one-cycle pulses, except o_held, which is a level.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_1S,
    parameter int REPEAT_CYCLES     = REPEAT_200MS,
    parameter int REPEAT_ENABLE     = 1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn_stable,
    output logic o_short_pulse,
    output logic o_long_pulse,
    output logic o_repeat_pulse,
    output logic o_release_pulse,
    output logic o_held
);

    // A single counter serves both the long-press and repeat timing.
    localparam int MAX_CYCLES = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                                LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] LONG_TC   = CW'(LONG_PRESS_CYCLES - 1);
    localparam logic [CW-1:0] REPEAT_TC = CW'(REPEAT_CYCLES - 1);
    localparam logic          RPT_EN    = (REPEAT_ENABLE != 0);

    logic [1:0]    state;
    logic [CW-1:0] cnt;

    // FSM and counter. Pulses default low each cycle. Release is tested
    // before the terminal count, so a release on a terminal edge wins.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            o_short_pulse   <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
            o_release_pulse <= 1'b0;
            o_held          <= 1'b0;
        end else begin
            o_short_pulse   <= 1'b0;
            o_long_pulse    <= 1'b0;
            o_repeat_pulse  <= 1'b0;
            o_release_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_btn_stable) begin
                        state <= ST_PRESSED;
                        cnt   <= '0;
                    end
                end
                ST_PRESSED: begin
                    if (!i_btn_stable) begin
                        state         <= ST_IDLE;
                        cnt           <= '0;
                        o_short_pulse <= 1'b1;
                    end else if (cnt == LONG_TC) begin
                        state        <= ST_HELD;
                        cnt          <= '0;
                        o_long_pulse <= 1'b1;
                        o_held       <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_HELD: begin
                    if (!i_btn_stable) begin
                        state           <= ST_IDLE;
                        cnt             <= '0;
                        o_release_pulse <= 1'b1;
                        o_held          <= 1'b0;
                    end else if (cnt == REPEAT_TC) begin
                        cnt            <= '0;
                        o_repeat_pulse <= RPT_EN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    o_held <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier. Two instances share the stimulus: one
// with auto-repeat enabled and one with it disabled. Expected output
// vectors {short, long, repeat, release, held} come from the press timing
// (edge numbers relative to the first high sample). They are queued as
// stimulus is applied and compared after each edge.
module tb_btn_press_classifier;

    localparam int L = 10;
    localparam int R = 4;

    logic i_clk = 1'b0;
    logic i_reset;
    logic i_btn_stable;

    logic s1, l1, r1, rl1, h1;
    logic s0, l0, r0, rl0, h0;

    int vectors = 0;
    int errors  = 0;
    logic [4:0] exp_q[$];

    always #5 i_clk = ~i_clk;

    btn_press_classifier #(
        .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_ENABLE(1)
    ) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn_stable(i_btn_stable),
        .o_short_pulse(s1), .o_long_pulse(l1), .o_repeat_pulse(r1),
        .o_release_pulse(rl1), .o_held(h1)
    );

    btn_press_classifier #(
        .LONG_PRESS_CYCLES(L), .REPEAT_CYCLES(R), .REPEAT_ENABLE(0)
    ) dut_norpt (
        .i_clk(i_clk), .i_reset(i_reset), .i_btn_stable(i_btn_stable),
        .o_short_pulse(s0), .o_long_pulse(l0), .o_repeat_pulse(r0),
        .o_release_pulse(rl0), .o_held(h0)
    );

    // Expected vector after edge e of a press held high on edges 0..n-1
    // and released on edge n.
    function automatic logic [4:0] press_exp(input int n, input int e);
        logic [4:0] v;
        v = 5'b0;
        if (n <= L) begin
            if (e == n) v[4] = 1'b1;
        end else begin
            if (e == L) begin
                v[3] = 1'b1;
                v[0] = 1'b1;
            end else if (e > L && e < n) begin
                v[0] = 1'b1;
                if (((e - L) % R) == 0) v[2] = 1'b1;
            end else if (e == n) begin
                v[1] = 1'b1;
            end
        end
        return v;
    endfunction

    // Apply one edge of stimulus with its expectation, then compare both instances.
    task automatic apply(input logic btn, input logic rst, input logic [4:0] e,
                         input string name);
        logic [4:0] want;
        logic [4:0] got1, got0;
        i_btn_stable = btn;
        i_reset      = rst;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        want = exp_q.pop_front();
        got1 = {s1, l1, r1, rl1, h1};
        got0 = {s0, l0, r0, rl0, h0};
        vectors++;
        if (got1 !== want) begin
            errors++;
            $display("FAIL %s rpt_en=1 t=%0t got=%b want=%b", name, $time, got1, want);
        end
        vectors++;
        if (got0 !== (want & 5'b11011)) begin
            errors++;
            $display("FAIL %s rpt_en=0 t=%0t got=%b want=%b", name, $time, got0,
                     want & 5'b11011);
        end
    endtask

    // A complete press of n high edges, the release edge, and one idle edge.
    task automatic run_press(input int n, input string name);
        for (int e = 0; e <= n; e++)
            apply(e < n, 1'b0, press_exp(n, e), name);
        apply(1'b0, 1'b0, 5'b0, {name, "_idle"});
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++)
            apply(1'b1, 1'b1, 5'b0, "reset_hold");
        // Button still high: the press counts from the first non-reset edge.
        run_press(5, "reset_exit_press");
    endtask

    task automatic test_short();
        run_press(5, "short");
        run_press(1, "short_min");
    endtask

    task automatic test_long_boundary();
        run_press(L, "long_minus1");
        run_press(L + 1, "long_exact");
    endtask

    task automatic test_repeat();
        run_press(20, "repeat");
    endtask

    task automatic test_release_on_terminal();
        run_press(14, "release_on_tc");
    endtask

    task automatic test_reset_mid_hold();
        for (int e = 0; e < 15; e++)
            apply(1'b1, 1'b0, press_exp(100, e), "midhold_pre");
        apply(1'b1, 1'b1, 5'b0, "midhold_reset");
        apply(1'b1, 1'b1, 5'b0, "midhold_reset2");
        run_press(L + 2, "midhold_after");
    endtask

    task automatic test_back_to_back();
        run_press(L + 1, "b2b_long");
        run_press(3, "b2b_short");
    endtask

    initial begin
        i_reset      = 1'b1;
        i_btn_stable = 1'b1;
        test_reset();
        test_short();
        test_long_boundary();
        test_repeat();
        test_release_on_terminal();
        test_reset_mid_hold();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
